// File: rtl/cba_operand_sequencer_if.sv
// Bundle of signals between the operand sequencer, its word streams and the external carry-bypass adder.
// The master side is the sequencer; the slave side is the stream/adder environment.
interface cba_operand_sequencer_if #(
  parameter int K = 32,
  parameter int W = 32
);
  localparam int N = 4 * K;

  // input word stream
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_cin;

  // adder side
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N-1:0] add_sum;
  logic [K-1:0] add_cout;

  // result word stream
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_cout;
  logic [K-1:0] out_gcout;
  logic         busy;

  modport master (
    input  in_valid, in_data, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin,
           out_valid, out_data, out_last, out_cout, out_gcout, busy
  );

  modport slave (
    output in_valid, in_data, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin,
           out_valid, out_data, out_last, out_cout, out_gcout, busy
  );
endinterface

// File: rtl/cba_operand_sequencer.sv
// Loads two N-bit operands over a W-bit stream, holds them on the carry-bypass adder for a
// fixed settle interval, captures sum/group carries and streams the result back out.
module cba_operand_sequencer #(
  parameter int K      = 32,
  parameter int W      = 32,
  parameter int SETTLE = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cba_operand_sequencer_if.master bus
);
  localparam int N     = 4 * K;
  localparam int BEATS = N / W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE);

  if ((N % W) != 0 || SETTLE < 0) begin : g_bad_params
    $error("cba_operand_sequencer: N must be a multiple of W and SETTLE >= 0");
  end

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DRAIN   = 3'd4
  } state_e;

  state_e        state_q,  state_d;
  logic [BW-1:0] beat_q,   beat_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [N-1:0]  a_q,      a_d;
  logic [N-1:0]  b_q,      b_d;
  logic          cin_q,    cin_d;
  logic [N-1:0]  res_q,    res_d;
  logic [K-1:0]  gcout_q,  gcout_d;

  logic in_ready, out_valid, out_last, in_xfer, out_xfer;

  // in_ready is gated by rst_n so the stream sees the block as closed while reset is held.
  assign in_ready  = rst_n & ((state_q == S_LOAD_A) | (state_q == S_LOAD_B));
  assign out_valid = (state_q == S_DRAIN);
  assign out_last  = out_valid & (beat_q == LAST_BEAT);
  assign in_xfer   = bus.in_valid & in_ready;
  assign out_xfer  = out_valid & bus.out_ready;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    res_d    = res_q;
    gcout_d  = gcout_q;
    case (state_q)
      S_LOAD_A: begin
        if (in_xfer) begin
          a_d[beat_q*W +: W] = bus.in_data;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_LOAD_B;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (in_xfer) begin
          b_d[beat_q*W +: W] = bus.in_data;
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            cin_d    = bus.in_cin;
            settle_d = '0;
            state_d  = S_SETTLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      // Adder inputs are untouched here; the counter only measures the ripple/bypass delay.
      S_SETTLE: begin
        if (settle_q == SETTLE_END) state_d = S_CAPTURE;
        else                        settle_d = settle_q + 1'b1;
      end
      S_CAPTURE: begin
        res_d   = bus.add_sum;
        gcout_d = bus.add_cout;
        beat_d  = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_xfer) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_LOAD_A;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        beat_d  = '0;
        state_d = S_LOAD_A;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD_A;
      beat_q   <= '0;
      settle_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      res_q    <= '0;
      gcout_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      res_q    <= res_d;
      gcout_q  <= gcout_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.add_a     = a_q;
  assign bus.add_b     = b_q;
  assign bus.add_cin   = cin_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? res_q[beat_q*W +: W] : '0;
  assign bus.out_last  = out_last;
  assign bus.out_cout  = gcout_q[K-1] & out_last;
  assign bus.out_gcout = gcout_q;
  assign bus.busy      = !((state_q == S_LOAD_A) && (beat_q == '0));

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && out_valid));
  a_drain_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !bus.out_ready) |=> (out_valid && $stable(bus.out_data) && $stable(out_last)));
endmodule

// File: tb/tb_cba_operand_sequencer.sv
// Bench for cba_operand_sequencer: table of operand/result vectors plus hand sequences for
// stalls, latency, mid-operation reset and back-to-back loads; results go through a scoreboard.
`timescale 1ns/1ps
module tb_cba_operand_sequencer;
  localparam int K = 32, W = 32, N = 128, BEATS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // sel=0 drives the SETTLE=4 instance, sel=1 the SETTLE=0 instance
  logic         sel = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_cin = 1'b0;
  logic         out_ready = 1'b1;

  cba_operand_sequencer_if #(.K(K), .W(W)) b4 ();
  cba_operand_sequencer_if #(.K(K), .W(W)) b0 ();

  cba_operand_sequencer #(.K(K), .W(W), .SETTLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  cba_operand_sequencer #(.K(K), .W(W), .SETTLE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  // nibble-group adder: returns {group carries, sum}
  function automatic logic [K+N-1:0] cba_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic cin);
    logic [N-1:0] s;
    logic [K-1:0] gc;
    logic         c;
    logic [4:0]   t;
    c = cin;
    for (int g = 0; g < K; g++) begin
      t = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + {4'b0, c};
      s[4*g +: 4] = t[3:0];
      c = t[4];
      gc[g] = c;
    end
    return {gc, s};
  endfunction

  always_comb {b4.add_cout, b4.add_sum} = cba_model(b4.add_a, b4.add_b, b4.add_cin);
  always_comb {b0.add_cout, b0.add_sum} = cba_model(b0.add_a, b0.add_b, b0.add_cin);

  assign b4.in_valid  = in_valid & ~sel;
  assign b0.in_valid  = in_valid & sel;
  assign b4.in_data   = in_data;
  assign b0.in_data   = in_data;
  assign b4.in_cin    = in_cin;
  assign b0.in_cin    = in_cin;
  assign b4.out_ready = out_ready & ~sel;
  assign b0.out_ready = out_ready & sel;

  logic         m_in_ready, m_out_valid, m_out_last, m_out_cout, m_busy, m_add_cin;
  logic [W-1:0] m_out_data;
  logic [K-1:0] m_out_gcout;
  logic [N-1:0] m_add_a, m_add_b;
  assign m_in_ready  = sel ? b0.in_ready  : b4.in_ready;
  assign m_out_valid = sel ? b0.out_valid : b4.out_valid;
  assign m_out_last  = sel ? b0.out_last  : b4.out_last;
  assign m_out_cout  = sel ? b0.out_cout  : b4.out_cout;
  assign m_busy      = sel ? b0.busy      : b4.busy;
  assign m_add_cin   = sel ? b0.add_cin   : b4.add_cin;
  assign m_out_data  = sel ? b0.out_data  : b4.out_data;
  assign m_out_gcout = sel ? b0.out_gcout : b4.out_gcout;
  assign m_add_a     = sel ? b0.add_a     : b4.add_a;
  assign m_add_b     = sel ? b0.add_b     : b4.add_b;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         last;
    logic         cout;
    logic [K-1:0] gc;
  } beat_t;
  beat_t sb[$];

  task automatic push_exp(input logic [N-1:0] sum, input logic [K-1:0] gc);
    beat_t e;
    for (int i = 0; i < BEATS; i++) begin
      e.d    = sum[i*W +: W];
      e.last = (i == BEATS - 1);
      e.cout = gc[K-1] & e.last;
      e.gc   = gc;
      sb.push_back(e);
    end
  endtask

  // monitor: sampled on the falling edge, a transfer happens at the following rising edge
  int cyc = 0, spur = 0, overlap = 0, ir_viol = 0, rise_cyc = -1, cur_beat = 0;
  int stall_beat = -1, stall_left = 0, last_b_cyc = 0;
  logic watch_ir = 1'b0, prev_ov = 1'b0, stalled = 1'b0;
  logic [W+1:0] held;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    beat_t e;
    if (m_in_ready && m_out_valid) overlap++;
    if (watch_ir && m_in_ready) ir_viol++;
    if (m_out_valid && !prev_ov) rise_cyc = cyc;
    prev_ov = m_out_valid;
    if (stalled && m_out_valid) chk("stall_hold", {m_out_data, m_out_last, m_out_cout}, held);
    stalled = m_out_valid && !out_ready;
    held = {m_out_data, m_out_last, m_out_cout};
    if (m_out_valid && out_ready) begin
      if (sb.size() == 0) spur++;
      else begin
        e = sb.pop_front();
        chk("out_data",  m_out_data,  e.d);
        chk("out_last",  m_out_last,  e.last);
        chk("out_cout",  m_out_cout,  e.cout);
        chk("out_gcout", m_out_gcout, e.gc);
      end
      cur_beat = m_out_last ? 0 : cur_beat + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_out_valid && cur_beat == stall_beat && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Called at posedge+1. Optional idle gap after word index gap_after; optional add_a retention check.
  task automatic send_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                         input int gap_after, input int gap_len,
                         input logic chk_hold, input logic [N-1:0] prev_a);
    int t;
    watch_ir = 1'b0;
    rise_cyc = -1;
    for (int i = 0; i < 2*BEATS; i++) begin
      in_valid = 1'b1;
      in_data  = (i < BEATS) ? a[i*W +: W] : b[(i-BEATS)*W +: W];
      in_cin   = (i == 2*BEATS - 1) ? cin : ~cin;
      t = 0;
      @(negedge clk);
      while (!m_in_ready && t < 200) begin @(negedge clk); t++; end
      if (!m_in_ready) chk("in_ready_timeout", 0, 1);
      if (i == 0 && chk_hold) chk("add_a_hold", m_add_a, prev_a);
      @(posedge clk); #1;
      if (i == 0) begin
        chk("busy_after_word0", m_busy, 1);
        if (chk_hold) chk("add_a_word0", m_add_a, {prev_a[N-1:W], a[W-1:0]});
      end
      if (i == 2*BEATS - 1) begin
        last_b_cyc = cyc;
        watch_ir = 1'b1;
      end
      in_valid = 1'b0;
      in_data  = ~in_data;
      if (i == gap_after) repeat (gap_len) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin @(negedge clk); #1; t++; end
    chk("drain_done", sb.size(), 0);
    @(posedge clk); #1;
    watch_ir = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] a, b;
    logic         cin;
    logic [N-1:0] sum;
    logic [K-1:0] gc;
    int           gap_after, gap_len, st_beat, st_len;
  } vec_t;
  vec_t tbl[9];

  initial begin : main
    logic [N-1:0] ones, one, msb, pat, r;
    logic [K+N-1:0] m;
    ones = '1; one = '0; one[0] = 1'b1; msb = '0; msb[N-1] = 1'b1;
    pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    tbl[0] = '{ones, '0, 1'b1, '0, 32'hFFFF_FFFF, -1, 0, -1, 0};
    tbl[1] = '{one, one, 1'b0, 128'h2, 32'h0, -1, 0, -1, 0};
    tbl[2] = '{ones, '0, 1'b1, '0, 32'hFFFF_FFFF, 1, 2, 1, 3};
    tbl[3] = '{128'hF, one, 1'b0, 128'h10, 32'h1, -1, 0, -1, 0};
    tbl[4] = '{msb, msb, 1'b0, '0, 32'h8000_0000, -1, 0, 2, 1};
    tbl[5] = '{msb, msb, 1'b1, one, 32'h8000_0000, -1, 0, -1, 0};
    tbl[6] = '{pat, '0, 1'b0, pat, 32'h0, 3, 1, 3, 2};
    for (int i = 7; i < 9; i++) begin
      tbl[i].a = {$urandom, $urandom, $urandom, $urandom};
      tbl[i].b = {$urandom, $urandom, $urandom, $urandom};
      tbl[i].cin = 1'($urandom_range(1));
      m = cba_model(tbl[i].a, tbl[i].b, tbl[i].cin);
      tbl[i].sum = m[N-1:0];
      tbl[i].gc  = m[K+N-1:N];
      tbl[i].gap_after = 5; tbl[i].gap_len = 1; tbl[i].st_beat = 0; tbl[i].st_len = 1;
    end

    // reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", m_in_ready, 0);
    chk("rst_outs", {m_out_valid, m_out_data, m_out_last, m_out_cout, m_out_gcout, m_busy},  '0);
    chk("rst_add", {m_add_a[63:0], m_add_b[63:0]}, '0);
    rst_n = 1'b1; #1;
    chk("in_ready_after_rst", m_in_ready, 1);
    chk("busy_idle", m_busy, 0);
    @(posedge clk); #1;

    // table vectors on the SETTLE=4 instance, latency checked on each
    for (int i = 0; i < 9; i++) begin
      push_exp(tbl[i].sum, tbl[i].gc);
      stall_beat = tbl[i].st_beat; stall_left = tbl[i].st_len;
      send_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].gap_after, tbl[i].gap_len, 1'b0, '0);
      chk("add_cin", m_add_cin, tbl[i].cin);
      wait_drain();
      chk("latency_s4", rise_cyc, last_b_cyc + 6);
    end
    stall_left = 0;
    chk("gcout_retained", m_out_gcout, tbl[8].gc);

    // SETTLE=0 latency
    sel = 1'b1;
    push_exp(128'h2, '0);
    send_op(one, one, 1'b0, -1, 0, 1'b0, '0);
    wait_drain();
    chk("latency_s0", rise_cyc, last_b_cyc + 2);
    sel = 1'b0;
    @(posedge clk); #1;

    // reset during SETTLE: no result, fresh op afterwards
    send_op(ones, '0, 1'b1, -1, 0, 1'b0, '0);
    watch_ir = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    chk("abort_outs", {m_in_ready, m_out_valid, m_out_data, m_out_last, m_out_cout, m_busy}, '0);
    chk("abort_gcout", m_out_gcout, '0);
    chk("abort_add", {m_add_a[N-1:N-64], m_add_cin}, '0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk("in_ready_after_abort", m_in_ready, 1);
    cur_beat = 0;
    repeat (10) begin @(posedge clk); #1; end
    chk("no_out_after_abort", spur, 0);
    push_exp(128'h2, '0);
    send_op(one, one, 1'b0, -1, 0, 1'b0, '0);
    wait_drain();

    // back-to-back: case 1 then case 2, add_a retained until first new A word
    push_exp('0, 32'hFFFF_FFFF);
    send_op(ones, '0, 1'b1, -1, 0, 1'b0, '0);
    push_exp(128'h2, '0);
    send_op(one, one, 1'b0, -1, 0, 1'b1, ones);
    wait_drain();

    chk("no_spurious", spur, 0);
    chk("no_overlap", overlap, 0);
    chk("in_ready_low_while_busy", ir_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: timeout reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/cba_operand_sequencer.md
Name: cba_operand_sequencer

Overview:
Sequencing stage directly upstream and downstream of the combinational carry-bypass adder a_n_cba.
- Collects two 4*K-bit operands and a carry-in over a narrow W-bit valid/ready input stream, then drives them stably onto the adder.
- Waits a fixed settle interval to cover the adder's ripple/bypass delay.
- Captures the sum and group carries, and streams the result back out in W-bit beats.

Parameters:
K, 32, number of 4-bit adder groups; operand width N = 4*K.
W, 32, stream word width; N must be an integer multiple of W; BEATS = N/W.
SETTLE, 4, clock cycles the adder inputs are held before capture (0 legal).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input word valid.
in_ready  output  1  sequencer accepts input word.
in_data  input  W  operand word, least-significant word first.
in_cin  input  1  carry-in; sampled only on the final B beat.
add_a  output  N  operand A to adder.
add_b  output  N  operand B to adder.
add_cin  output  1  carry-in to adder.
add_sum  input  N  adder sum.
add_cout  input  K  adder per-group carry-outs.
out_valid  output  1  result word valid.
out_ready  input  1  downstream accepts result word.
out_data  output  W  result word, least-significant word first.
out_last  output  1  marks final result beat.
out_cout  output  1  final carry (captured add_cout[K-1]); valid when out_last=1, else 0.
out_gcout  output  K  captured group carry vector; stable for the whole drain.
busy  output  1  high in every state except LOAD_A with beat count 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD_A, beat counter=0, settle counter=0.
  - A, B, cin, result and gcout registers cleared.
  - Outputs: add_a=0, add_b=0, add_cin=0, out_valid=0, out_data=0, out_last=0, out_cout=0, out_gcout=0, busy=0.
  - in_ready goes to 1 as soon as reset deasserts.
- Reset mid-operation: aborts immediately; no partial result is ever emitted.
- Handshake: a transfer occurs on a rising edge with valid=1 and ready=1. Idle cycles (valid=0) never advance counters.
- States:
  - LOAD_A: in_ready=1. Each transfer writes in_data into A[beat*W +: W] and increments beat. The transfer at beat=BEATS-1 resets beat to 0 and moves to LOAD_B.
  - LOAD_B: in_ready=1. Same write rule into B. The final beat also latches in_cin into add_cin and moves to SETTLE with settle counter=0.
  - SETTLE: in_ready=0. add_a, add_b and add_cin are held constant. Counter increments each cycle; when counter==SETTLE, move to CAPTURE. For SETTLE=0, SETTLE lasts exactly one cycle.
  - CAPTURE: one cycle. Register add_sum into the result register and add_cout into gcout, then move to DRAIN with beat=0.
  - DRAIN: out_valid=1, out_data=result[beat*W +: W], out_last=(beat==BEATS-1), out_cout=gcout[K-1]&out_last. Each transfer increments beat. The last transfer clears out_valid, sets beat to 0 and returns to LOAD_A.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and out_cout hold unchanged.
- Latency: if the final B beat is accepted at edge E, then out_valid rises after edge E+SETTLE+2.
- Register retention:
  - add_a, add_b and add_cin are registered and keep their last values through DRAIN and the next load; A and B are overwritten word-by-word.
  - out_gcout holds its value until the next CAPTURE.
- Arithmetic: the block does none; sum width N, no truncation. Carry out of bit N-1 is reported only via out_cout.
- No simultaneous input and output phases: in_ready and out_valid are never both 1.

Test Plan:
1. K=32,W=32,SETTLE=4: A=FFFF…FF (4 beats), B=0, cin=1 -> 4 beats of 0x00000000, out_last on beat 4, out_cout=1, out_gcout=0xFFFFFFFF.
2. A=0x…0001, B=0x…0001, cin=0 -> beats 0x00000002,0,0,0; out_cout=0, out_gcout=0.
3. Case 1 with in_valid low for 2 cycles between beats 2 and 3 of A, then out_ready low for 3 cycles on result beat 2 -> identical result, no skipped or duplicated words, out_data stable while stalled.
4. Latency check, SETTLE=4 then SETTLE=0: final B beat at edge E -> out_valid first high after E+6, resp. E+2; in_ready=0 from E until the last out transfer.
5. Assert rst_n=0 during SETTLE of case 1 -> all outputs 0 immediately; after release, in_ready=1, out_valid stays 0, and a fresh case 2 load produces case 2 results.
6. Back-to-back: case 1 followed immediately by case 2 with out_ready tied 1 -> second result correct; add_a holds FFFF…FF until first A word of case 2 is accepted.
